// File: rtl/bcd_stopwatch_n_pkg.sv
// Shared definitions for the typing-test stopwatch datapath and the game FSM.
package bcd_stopwatch_n_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    FULL   = 2'd3
  } state_t;

  // 100 MHz clock, 10 Hz LSD rate
  localparam int unsigned DEFAULT_CLKS_PER_TICK = 10_000_000;
  localparam logic [3:0]  BCD_MAX               = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_n_digit.sv
// One BCD digit, 0..9. carry_out is a pure function of inc_in and the digit,
// so the saturation hold never feeds back into the carry chain.
module bcd_digit
  import bcd_stopwatch_n_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc_in,
  input  logic       hold,
  output logic [3:0] digit,
  output logic       carry_out
);

  assign carry_out = inc_in && (digit == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digit <= '0;
    end else if (inc_in && !hold) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_n.sv
// NUM_DIGITS-digit BCD stopwatch: run/pause/clear control, prescaler,
// ripple digit chain, lap snapshot and saturate-or-wrap overflow.
module bcd_stopwatch_n
  import bcd_stopwatch_n_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK,
  parameter bit          SATURATE      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    freeze,
  output logic                    running,
  output logic                    tick,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [4*NUM_DIGITS-1:0] snap_out,
  output logic                    snap_valid,
  output logic                    overflow
);

  localparam int unsigned   PW        = $clog2(CLKS_PER_TICK);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic          wrap;
  logic          all9;
  logic          sat_hit;

  // Increment request: stop, clear and rst all veto the wrap cycle.
  assign wrap    = (state == RUN) && !rst && !clear && !stop && (presc == PRESC_MAX);
  assign sat_hit = SATURATE && all9;
  assign tick    = wrap && !sat_hit;
  assign running = (state == RUN);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic       inc;
    logic       carry;
    logic [3:0] d;

    if (k == 0) begin : g_lsd
      assign inc = wrap;
    end else begin : g_upper
      assign inc = g_digit[k-1].carry;
    end

    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .inc_in    (inc),
      .hold      (sat_hit),
      .digit     (d),
      .carry_out (carry)
    );

    assign digits_out[4*k +: 4] = d;
  end

  // Carry out of the top digit is the AND of the whole chain: all 9s and incrementing.
  assign all9 = g_digit[NUM_DIGITS-1].carry;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= IDLE;
      presc      <= '0;
      overflow   <= 1'b0;
      snap_out   <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (freeze) begin
        snap_out   <= digits_out;
        snap_valid <= 1'b1;
      end
      overflow <= SATURATE ? overflow : 1'b0;

      case (state)
        IDLE, PAUSED: begin
          if (!stop && start) state <= RUN;
        end
        RUN: begin
          if (stop) begin
            state <= PAUSED;
          end else if (presc == PRESC_MAX) begin
            presc <= '0;
            if (all9) begin
              overflow <= 1'b1;
              if (SATURATE) state <= FULL;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        FULL: state <= FULL;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_n.sv
// Bench for bcd_stopwatch_n: a saturating and a wrapping instance share stimulus;
// expected digit values are queued per tick and checked after each increment edge.
module tb_bcd_stopwatch_n;

  logic        clk = 1'b0;
  logic        rst, clear, start, stop, freeze;
  logic        run_s, tick_s, sv_s, ov_s;
  logic        run_w, tick_w, sv_w, ov_w;
  logic [11:0] d_s, snap_s, d_w, snap_w;

  int          total = 0;
  int          bad   = 0;
  logic [11:0] exp_q[$];
  bit          pend  = 1'b0;

  always #5 clk = ~clk;

  bcd_stopwatch_n #(.NUM_DIGITS(3), .CLKS_PER_TICK(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop), .freeze(freeze),
    .running(run_s), .tick(tick_s), .digits_out(d_s), .snap_out(snap_s),
    .snap_valid(sv_s), .overflow(ov_s)
  );

  bcd_stopwatch_n #(.NUM_DIGITS(3), .CLKS_PER_TICK(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .stop(stop), .freeze(freeze),
    .running(run_w), .tick(tick_w), .digits_out(d_w), .snap_out(snap_w),
    .snap_valid(sv_w), .overflow(ov_w)
  );

  // Scoreboard: a tick seen on one negedge is checked against the queue on the next.
  always @(negedge clk) begin
    logic [11:0] e;
    if (pend) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: digits=%h, none expected", d_s);
      end else begin
        e = exp_q.pop_front();
        if (d_s !== e) begin
          bad++;
          $display("FAIL sb_digits: got %h want %h", d_s, e);
        end
      end
      pend = 1'b0;
    end
    if (tick_s === 1'b1) pend = 1'b1;
  end

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  task automatic push_ticks(input logic [11:0] from, input int n);
    logic [11:0] v;
    v = from;
    for (int i = 0; i < n; i++) begin
      v = bcd_inc(v);
      exp_q.push_back(v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic stop_and_clear;
    stop = 1'b1; cyc(1); stop = 1'b0;
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; start = 1'b0; stop = 1'b0; freeze = 1'b0;
    cyc(3);
    rst = 1'b0;
    total++;
    if ({run_s, tick_s, sv_s, ov_s, d_s, snap_s} !== 28'h0) begin
      bad++;
      $display("FAIL reset_sat: got %h want 0", {run_s, tick_s, sv_s, ov_s, d_s, snap_s});
    end
    total++;
    if ({run_w, tick_w, sv_w, ov_w, d_w, snap_w} !== 28'h0) begin
      bad++;
      $display("FAIL reset_wrap: got %h want 0", {run_w, tick_w, sv_w, ov_w, d_w, snap_w});
    end
    cyc(5);
    total++;
    if ({run_s, d_s} !== 13'h0) begin
      bad++;
      $display("FAIL idle_hold: got run=%b digits=%h want 0/000", run_s, d_s);
    end
  endtask

  task automatic test_count;
    pulse_start();
    total++;
    if (run_s !== 1'b1) begin
      bad++;
      $display("FAIL start_latency: running=%b want 1", run_s);
    end
    push_ticks(12'h000, 10);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      total++;
      if (tick_s !== (i % 4 == 0)) begin
        bad++;
        $display("FAIL tick_spacing: cycle %0d tick=%b want %b", i, tick_s, (i % 4 == 0));
      end
      @(posedge clk); #1;
    end
    total++;
    if ({run_s, d_s} !== {1'b1, 12'h010}) begin
      bad++;
      $display("FAIL count40: got run=%b digits=%h want 1/010", run_s, d_s);
    end
    stop_and_clear();
    total++;
    if ({run_s, d_s} !== 13'h0) begin
      bad++;
      $display("FAIL clear: got run=%b digits=%h want 0/000", run_s, d_s);
    end
  endtask

  task automatic test_pause_resume;
    pulse_start();
    push_ticks(12'h000, 10);
    cyc(36);
    total++;
    if (d_s !== 12'h009) begin
      bad++;
      $display("FAIL run_to_9: got %h want 009", d_s);
    end
    cyc(2);
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(20);
    total++;
    if ({run_s, d_s} !== {1'b0, 12'h009}) begin
      bad++;
      $display("FAIL paused_hold: got run=%b digits=%h want 0/009", run_s, d_s);
    end
    pulse_start();
    total++;
    if (run_s !== 1'b1) begin
      bad++;
      $display("FAIL resume: running=%b want 1", run_s);
    end
    @(negedge clk);
    total++;
    if (tick_s !== 1'b0) begin
      bad++;
      $display("FAIL resume_frac1: tick=%b want 0", tick_s);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (tick_s !== 1'b1) begin
      bad++;
      $display("FAIL resume_frac2: tick=%b want 1", tick_s);
    end
    @(posedge clk); #1;
    total++;
    if (d_s !== 12'h010) begin
      bad++;
      $display("FAIL resume_carry: got %h want 010", d_s);
    end
    stop_and_clear();
  endtask

  task automatic test_freeze;
    pulse_start();
    push_ticks(12'h000, 48);
    cyc(188);
    freeze = 1'b1; cyc(1); freeze = 1'b0;
    total++;
    if ({sv_s, snap_s} !== {1'b1, 12'h047}) begin
      bad++;
      $display("FAIL freeze: got valid=%b snap=%h want 1/047", sv_s, snap_s);
    end
    cyc(3);
    total++;
    if ({d_s, snap_s} !== {12'h048, 12'h047}) begin
      bad++;
      $display("FAIL freeze_live: got digits=%h snap=%h want 048/047", d_s, snap_s);
    end
    freeze = 1'b1; clear = 1'b1; cyc(1); freeze = 1'b0; clear = 1'b0;
    total++;
    if ({run_s, sv_s, snap_s, d_s} !== 26'h0) begin
      bad++;
      $display("FAIL freeze_clear: got run=%b valid=%b snap=%h digits=%h want 0", run_s, sv_s, snap_s, d_s);
    end
  endtask

  task automatic test_start_stop_rst;
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    cyc(8);
    total++;
    if ({run_s, d_s} !== 13'h0) begin
      bad++;
      $display("FAIL start_stop_idle: got run=%b digits=%h want 0/000", run_s, d_s);
    end
    pulse_start();
    push_ticks(12'h000, 123);
    cyc(492);
    freeze = 1'b1; cyc(1); freeze = 1'b0;
    cyc(2);
    total++;
    if ({d_s, snap_s} !== {12'h123, 12'h123}) begin
      bad++;
      $display("FAIL run_to_123: got digits=%h snap=%h want 123/123", d_s, snap_s);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tick_s !== 1'b0) begin
      bad++;
      $display("FAIL rst_tick: tick=%b want 0", tick_s);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({run_s, tick_s, sv_s, ov_s, d_s, snap_s} !== 28'h0) begin
      bad++;
      $display("FAIL rst_midrun: got %h want 0", {run_s, tick_s, sv_s, ov_s, d_s, snap_s});
    end
  endtask

  task automatic test_overflow;
    pulse_start();
    push_ticks(12'h000, 999);
    cyc(3996);
    total++;
    if ({d_s, d_w, run_s, run_w} !== {12'h999, 12'h999, 2'b11}) begin
      bad++;
      $display("FAIL run_to_999: got sat=%h wrap=%h run=%b%b want 999/999/11", d_s, d_w, run_s, run_w);
    end
    cyc(3);
    @(negedge clk);
    total++;
    if ({tick_s, tick_w} !== 2'b01) begin
      bad++;
      $display("FAIL ovf_tick: got sat=%b wrap=%b want 0/1", tick_s, tick_w);
    end
    @(posedge clk); #1;
    total++;
    if ({d_s, ov_s, run_s} !== {12'h999, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sat_hold: got digits=%h ovf=%b run=%b want 999/1/0", d_s, ov_s, run_s);
    end
    total++;
    if ({d_w, ov_w, run_w} !== {12'h000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL wrap_zero: got digits=%h ovf=%b run=%b want 000/1/1", d_w, ov_w, run_w);
    end
    cyc(1);
    total++;
    if ({ov_s, ov_w} !== 2'b10) begin
      bad++;
      $display("FAIL ovf_shape: got sat=%b wrap=%b want 1/0", ov_s, ov_w);
    end
    pulse_start();
    total++;
    if ({run_s, d_s} !== {1'b0, 12'h999}) begin
      bad++;
      $display("FAIL full_ignores_start: got run=%b digits=%h want 0/999", run_s, d_s);
    end
    cyc(2);
    total++;
    if (d_w !== 12'h001) begin
      bad++;
      $display("FAIL wrap_continues: got %h want 001", d_w);
    end
    stop_and_clear();
    total++;
    if ({d_s, ov_s, run_s} !== 14'h0) begin
      bad++;
      $display("FAIL full_clear: got digits=%h ovf=%b run=%b want 000/0/0", d_s, ov_s, run_s);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause_resume();
    test_freeze();
    test_start_stop_rst();
    test_overflow();
    cyc(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d queued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
